waves_window_ctrl: RTL

Cycle-accurate scheduler for simulation waveform dumping. It decides when the waves dump is active: after an optional trigger and start delay, it opens one or more dump windows of programmed length separated by programmed gaps. It sits beside the waves package in the testbench top. Its `dump_on`/`dump_off` pulses drive the `$dumpon`/`$dumpoff` calls, and `dump_en` gates any tracer. It is synthesizable RTL so it also runs under Verilator.

---
 rtl/waves_window_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/waves_window_ctrl.sv
// Waveform dump window scheduler.
// After an optional trigger and start delay, opens one or more dump windows of
// programmed length separated by programmed gaps.
// Ports:
//   clock, reset_n           - clock, async active-low reset
//   cfg_enable               - level; high starts a session, low returns to IDLE
//   cfg_use_trigger          - wait for trigger before the start delay
//   cfg_start_delay          - cycles between start/trigger and the first window
//   cfg_window_len           - dump_en high cycles per window (0 treated as 1)
//   cfg_gap_len              - dump_en low cycles between windows
//   cfg_num_windows          - number of windows, 0 = unlimited
//   trigger                  - trigger input, sampled only while waiting for it
//   abort                    - ends the session early (goes to DONE)
//   dump_en                  - dump active
//   dump_on / dump_off       - one-cycle pulses at dump_en rise / fall
//   window_idx               - completed windows in this session
//   busy / done              - session running / session finished
module waves_window_ctrl #(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned WIN_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             cfg_enable,
    input  logic             cfg_use_trigger,
    input  logic [CNT_W-1:0] cfg_start_delay,
    input  logic [CNT_W-1:0] cfg_window_len,
    input  logic [CNT_W-1:0] cfg_gap_len,
    input  logic [WIN_W-1:0] cfg_num_windows,
    input  logic             trigger,
    input  logic             abort,
    output logic             dump_en,
    output logic             dump_on,
    output logic             dump_off,
    output logic [WIN_W-1:0] window_idx,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_TRIG,
        S_DELAY,
        S_ON,
        S_GAP,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic [WIN_W-1:0] idx_d;

    // Session configuration captured when leaving IDLE
    logic [CNT_W-1:0] lat_start_delay;
    logic [CNT_W-1:0] lat_window_len;
    logic [CNT_W-1:0] lat_gap_len;
    logic [WIN_W-1:0] lat_num_windows;
    logic             lat_load;

    logic [CNT_W-1:0] win_load;

    logic dump_en_d;
    logic dump_on_d;
    logic dump_off_d;
    logic busy_d;
    logic done_d;

    assign lat_load = (state == S_IDLE) && cfg_enable;

    // Window counter reload value; a zero length still gives one cycle
    assign win_load = (lat_window_len == '0) ? '0 : lat_window_len - CNT_W'(1);

    // State, counter, configuration and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            cnt             <= '0;
            window_idx      <= '0;
            lat_start_delay <= '0;
            lat_window_len  <= '0;
            lat_gap_len     <= '0;
            lat_num_windows <= '0;
            dump_en         <= 1'b0;
            dump_on         <= 1'b0;
            dump_off        <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            window_idx <= idx_d;
            if (lat_load) begin
                lat_start_delay <= cfg_start_delay;
                lat_window_len  <= cfg_window_len;
                lat_gap_len     <= cfg_gap_len;
                lat_num_windows <= cfg_num_windows;
            end
            dump_en  <= dump_en_d;
            dump_on  <= dump_on_d;
            dump_off <= dump_off_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

    // Next state, counter and window index
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        idx_d   = window_idx;
        unique case (state)
            S_IDLE: begin
                if (cfg_enable) begin
                    state_d = cfg_use_trigger ? S_WAIT_TRIG : S_DELAY;
                    cnt_d   = cfg_start_delay;
                    idx_d   = '0;
                end
            end
            S_WAIT_TRIG: begin
                if (trigger) begin
                    state_d = S_DELAY;
                    cnt_d   = lat_start_delay;
                end
            end
            S_DELAY: begin
                if (cnt == '0) begin
                    state_d = S_ON;
                    cnt_d   = win_load;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            S_ON: begin
                if (cnt == '0) begin
                    idx_d = window_idx + WIN_W'(1);
                    if ((lat_num_windows != '0) && (idx_d == lat_num_windows)) begin
                        state_d = S_DONE;
                    end else if (lat_gap_len == '0) begin
                        // Back-to-back windows: dump_en stays high
                        cnt_d = win_load;
                    end else begin
                        state_d = S_GAP;
                        cnt_d   = lat_gap_len - CNT_W'(1);
                    end
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            S_GAP: begin
                if (cnt == '0) begin
                    state_d = S_ON;
                    cnt_d   = win_load;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            S_DONE: begin
                if (!cfg_enable) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Early termination; disable takes priority over abort
        if ((state != S_IDLE) && (state != S_DONE) && abort) begin
            state_d = S_DONE;
            cnt_d   = cnt;
            idx_d   = window_idx;
        end
        if ((state != S_IDLE) && !cfg_enable) begin
            state_d = S_IDLE;
            cnt_d   = cnt;
            idx_d   = window_idx;
        end
    end

    // Next output values, registered alongside the state
    always_comb begin
        dump_en_d  = (state_d == S_ON);
        dump_on_d  = dump_en_d && !dump_en;
        dump_off_d = dump_en && !dump_en_d;
        busy_d     = (state_d == S_WAIT_TRIG) || (state_d == S_DELAY) ||
                     (state_d == S_ON) || (state_d == S_GAP);
        done_d     = (state_d == S_DONE);
    end

endmodule
